// File: rtl/nanov_reg_serdes.sv
// nanov_reg_serdes
// Bridges the nanoV parallel memory interface and the 1-bit serial register file.
//   Load path : accepts a 32-bit load word, size/sign-extends it and streams it onto
//               the register file write port aligned to the core bit counter.
//   Store path: collects the serial rs2 read stream into a parallel 32-bit word.
// The two paths are fully independent and may overlap.
//
// Ports
//   clk, rstn              clock, synchronous active-low reset
//   counter[4:0]           core bit counter, increments every clk, wraps 31->0
//   ld_valid / ld_ready    load handshake (ld_ready high while the load path is idle)
//   ld_data[31:0]          raw load word, byte 0 in [7:0]
//   ld_size[1:0]           0=byte, 1=half, 2/3=word
//   ld_unsigned            1=zero-extend, 0=sign-extend
//   ld_rd                  destination register
//   rd                     latched destination presented to the register file
//   wr_en / data_rd        write data_rd into bit [counter] of rd
//   wr_next_en / data_rd_next  write data_rd_next into bit [counter+1] of rd
//   ld_done                one-cycle pulse while the last bit is written
//   st_req / st_busy       store capture request / capture pending or running
//   data_rs2               serial rs2 bit for the current counter
//   st_data[31:0]          captured store word
//   st_done                one-cycle pulse when st_data is updated
module nanov_reg_serdes #(
  parameter int unsigned REG_ADDR_BITS = 4,
  parameter int unsigned NUM_REGS      = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [4:0]               counter,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [31:0]              ld_data,
  input  logic [1:0]               ld_size,
  input  logic                     ld_unsigned,
  input  logic [REG_ADDR_BITS-1:0] ld_rd,
  output logic [REG_ADDR_BITS-1:0] rd,
  output logic                     wr_en,
  output logic                     wr_next_en,
  output logic                     data_rd,
  output logic                     data_rd_next,
  output logic                     ld_done,
  input  logic                     st_req,
  output logic                     st_busy,
  input  logic                     data_rs2,
  output logic [31:0]              st_data,
  output logic                     st_done
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    SHIFT = 2'd2
  } ld_state_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_CAP  = 2'd2
  } st_state_e;

  // Size/sign extension of the raw load word.
  function automatic logic [WORD_W-1:0] extend_word(input logic [WORD_W-1:0] d,
                                                    input logic [1:0]        sz,
                                                    input logic              uns);
    logic [WORD_W-1:0] r;
    case (sz)
      2'd0:    r = {{24{~uns & d[7]}}, d[7:0]};
      2'd1:    r = {{16{~uns & d[15]}}, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  // Counter values seen this cycle and the next; the counter advances by one every clk.
  logic [CNT_W-1:0] cnt_nxt;
  logic             cnt_last;
  logic             nxt_last;

  always_comb begin
    cnt_nxt  = counter + CNT_W'(1);
    cnt_last = (counter == CNT_W'(WORD_W - 1));
    nxt_last = (cnt_nxt == CNT_W'(WORD_W - 1));
  end

  // ---------------------------------------------------------------------------
  // Load path
  // ---------------------------------------------------------------------------
  ld_state_e                ld_state_q, ld_state_d;
  logic [WORD_W-1:0]        w_q, w_d;
  logic [REG_ADDR_BITS-1:0] rd_q, rd_d;
  logic                     ld_ready_q, ld_ready_d;
  logic                     wr_en_q, wr_en_d;
  logic                     wr_next_en_q, wr_next_en_d;
  logic                     data_rd_q, data_rd_d;
  logic                     data_rd_next_q, data_rd_next_d;
  logic                     ld_done_q, ld_done_d;
  logic                     rd_writable;

  // Next-state logic; the stream outputs are evaluated for the following cycle's
  // state and counter so that they leave the design straight from flops.
  always_comb begin
    ld_state_d     = ld_state_q;
    w_d            = w_q;
    rd_d           = rd_q;
    ld_ready_d     = 1'b0;
    wr_en_d        = 1'b0;
    wr_next_en_d   = 1'b0;
    data_rd_d      = 1'b0;
    data_rd_next_d = 1'b0;
    ld_done_d      = 1'b0;
    rd_writable    = 1'b0;

    unique case (ld_state_q)
      IDLE: begin
        if (ld_valid) begin
          rd_d       = ld_rd;
          w_d        = extend_word(ld_data, ld_size, ld_unsigned);
          ld_state_d = cnt_last ? SHIFT : ARM;
        end
      end
      ARM: begin
        if (cnt_last) ld_state_d = SHIFT;
      end
      SHIFT: begin
        if (cnt_last) ld_state_d = IDLE;
      end
      default: ld_state_d = IDLE;
    endcase

    // x0 and unimplemented registers keep the full timing but never write.
    rd_writable = (rd_d != '0) && (32'(rd_d) < NUM_REGS);
    ld_ready_d  = (ld_state_d == IDLE);

    if (ld_state_d == SHIFT) begin
      data_rd_d      = w_d[cnt_nxt];
      data_rd_next_d = nxt_last ? 1'b0 : w_d[cnt_nxt + CNT_W'(1)];
      wr_en_d        = rd_writable;
      wr_next_en_d   = rd_writable & ~nxt_last;
      ld_done_d      = nxt_last;
    end
  end

  // Load path registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ld_state_q     <= IDLE;
      w_q            <= '0;
      rd_q           <= '0;
      ld_ready_q     <= 1'b1;
      wr_en_q        <= 1'b0;
      wr_next_en_q   <= 1'b0;
      data_rd_q      <= 1'b0;
      data_rd_next_q <= 1'b0;
      ld_done_q      <= 1'b0;
    end else begin
      ld_state_q     <= ld_state_d;
      w_q            <= w_d;
      rd_q           <= rd_d;
      ld_ready_q     <= ld_ready_d;
      wr_en_q        <= wr_en_d;
      wr_next_en_q   <= wr_next_en_d;
      data_rd_q      <= data_rd_d;
      data_rd_next_q <= data_rd_next_d;
      ld_done_q      <= ld_done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Store path
  // ---------------------------------------------------------------------------
  st_state_e         st_state_q, st_state_d;
  logic [WORD_W-1:0] buf_q, buf_d;
  logic [WORD_W-1:0] st_data_q, st_data_d;
  logic              st_busy_q, st_busy_d;
  logic              st_done_q, st_done_d;

  // Capture FSM; the final bit is folded in directly so st_data updates the cycle after bit 31.
  always_comb begin
    st_state_d = st_state_q;
    buf_d      = buf_q;
    st_data_d  = st_data_q;
    st_busy_d  = 1'b0;
    st_done_d  = 1'b0;

    unique case (st_state_q)
      S_IDLE: begin
        if (st_req) st_state_d = cnt_last ? S_CAP : S_WAIT;
      end
      S_WAIT: begin
        if (cnt_last) st_state_d = S_CAP;
      end
      S_CAP: begin
        buf_d[counter] = data_rs2;
        if (cnt_last) begin
          st_state_d = S_IDLE;
          st_data_d  = buf_d;
          st_done_d  = 1'b1;
        end
      end
      default: st_state_d = S_IDLE;
    endcase

    st_busy_d = (st_state_d != S_IDLE);
  end

  // Store path registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      st_state_q <= S_IDLE;
      buf_q      <= '0;
      st_data_q  <= '0;
      st_busy_q  <= 1'b0;
      st_done_q  <= 1'b0;
    end else begin
      st_state_q <= st_state_d;
      buf_q      <= buf_d;
      st_data_q  <= st_data_d;
      st_busy_q  <= st_busy_d;
      st_done_q  <= st_done_d;
    end
  end

  assign ld_ready     = ld_ready_q;
  assign rd           = rd_q;
  assign wr_en        = wr_en_q;
  assign wr_next_en   = wr_next_en_q;
  assign data_rd      = data_rd_q;
  assign data_rd_next = data_rd_next_q;
  assign ld_done      = ld_done_q;
  assign st_busy      = st_busy_q;
  assign st_data      = st_data_q;
  assign st_done      = st_done_q;

endmodule

// File: tb/tb_nanov_reg_serdes.sv
// Scoreboard bench for nanov_reg_serdes: the stimulus process runs a transaction-level
// reference model and queues expected load/store completions; a negedge monitor
// compares the DUT streams and pulses against the queued expectations.
module tb_nanov_reg_serdes;

  logic        clk = 1'b0;
  logic        rstn;
  logic [4:0]  counter;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_data;
  logic [1:0]  ld_size;
  logic        ld_unsigned;
  logic [3:0]  ld_rd;
  logic [3:0]  rd;
  logic        wr_en;
  logic        wr_next_en;
  logic        data_rd;
  logic        data_rd_next;
  logic        ld_done;
  logic        st_req;
  logic        st_busy;
  logic        data_rs2;
  logic [31:0] st_data;
  logic        st_done;

  nanov_reg_serdes #(.REG_ADDR_BITS(4), .NUM_REGS(16)) dut (
    .clk(clk), .rstn(rstn), .counter(counter),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_size(ld_size),
    .ld_unsigned(ld_unsigned), .ld_rd(ld_rd), .rd(rd), .wr_en(wr_en),
    .wr_next_en(wr_next_en), .data_rd(data_rd), .data_rd_next(data_rd_next),
    .ld_done(ld_done), .st_req(st_req), .st_busy(st_busy), .data_rs2(data_rs2),
    .st_data(st_data), .st_done(st_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned done;
    logic [31:0] word;
    logic [3:0]  rd;
    bit          wr;
  } ld_exp_t;

  typedef struct {
    int unsigned done;
    logic [31:0] word;
  } st_exp_t;

  ld_exp_t     ld_q[$];
  st_exp_t     st_q[$];
  logic [31:0] rs2_words [256];
  int unsigned cyc;
  int unsigned ld_free;
  int unsigned st_free;
  int unsigned ld_acc_cnt;
  bit          exp_ld_ready;
  bit          exp_st_busy;
  int          errors;
  int          checks;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  // Load word as the register should finally hold it.
  function automatic logic [31:0] ref_extend(input logic [31:0] d, input logic [1:0] sz,
                                             input logic uns);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = d & 32'h0000_00FF;
      if (!uns && v >= 32'h80) v = v - 32'h100;
    end else if (sz == 2'd1) begin
      v = d & 32'h0000_FFFF;
      if (!uns && v >= 32'h8000) v = v - 32'h1_0000;
    end else begin
      v = d;
    end
    return v;
  endfunction

  // Transaction-level model of the current cycle's inputs.
  task automatic model_step();
    int unsigned c;
    int unsigned start;
    ld_exp_t     e;
    st_exp_t     s;
    c            = cyc % 32;
    exp_ld_ready = (cyc >= ld_free);
    exp_st_busy  = (cyc < st_free);
    // Transfers start on the first cycle whose counter is 0 after acceptance.
    start        = cyc - c + 32;
    if (!rstn) begin
      ld_free = cyc + 1;
      st_free = cyc + 1;
    end else begin
      if (ld_valid && exp_ld_ready) begin
        e.done = start + 31;
        e.word = ref_extend(ld_data, ld_size, ld_unsigned);
        e.rd   = ld_rd;
        e.wr   = (ld_rd != 4'd0) && (32'(ld_rd) < 32'd16);
        ld_q.push_back(e);
        ld_free = e.done + 1;
        ld_acc_cnt++;
      end
      if (st_req && !exp_st_busy) begin
        s.done = start + 32;
        s.word = rs2_words[8'(start / 32)];
        st_q.push_back(s);
        st_free = s.done;
      end
    end
  endtask

  task automatic tick();
    logic [31:0] w;
    model_step();
    @(posedge clk);
    #2;
    cyc++;
    counter  = 5'(cyc % 32);
    w        = rs2_words[8'(cyc / 32)];
    data_rs2 = w[5'(cyc % 32)];
  endtask

  task automatic wait_cnt(input int unsigned v);
    for (int n = 0; n < 40 && counter != 5'(v); n++) tick();
  endtask

  task automatic issue_load(input logic [31:0] d, input logic [1:0] sz, input logic uns,
                            input logic [3:0] r);
    ld_valid = 1'b1; ld_data = d; ld_size = sz; ld_unsigned = uns; ld_rd = r;
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic drain_ld();
    while (cyc < ld_free) tick();
  endtask

  task automatic drain_st();
    while (cyc < st_free) tick();
  endtask

  // Monitor state
  ld_exp_t     fe;
  int unsigned wi;
  logic [31:0] acc_d, acc_dn, acc_we, acc_wne;
  logic [31:0] cur_st;
  bit          after_rst;
  bit          st_hit;

  always @(negedge clk) begin
    if (cyc >= 1) begin
      check("ld_ready", 32'(ld_ready), 32'(exp_ld_ready));
      check("st_busy", 32'(st_busy), 32'(exp_st_busy));
      if (after_rst) begin
        check("rd_after_reset", 32'(rd), 32'd0);
        after_rst = 1'b0;
      end

      if (ld_q.size() > 0 && cyc + 31 >= ld_q[0].done) begin
        fe = ld_q[0];
        wi = cyc - (fe.done - 31);
        if (wi == 0) begin
          acc_d = '0; acc_dn = '0; acc_we = '0; acc_wne = '0;
        end
        acc_d[5'(wi)]   = data_rd;
        acc_dn[5'(wi)]  = data_rd_next;
        acc_we[5'(wi)]  = wr_en;
        acc_wne[5'(wi)] = wr_next_en;
        check("ld_done", 32'(ld_done), 32'(cyc == fe.done));
        if (cyc == fe.done) begin
          check("ld_rd", 32'(rd), 32'(fe.rd));
          check("ld_data_rd", acc_d, fe.word);
          check("ld_data_rd_next", acc_dn, fe.word >> 1);
          check("ld_wr_en", acc_we, fe.wr ? 32'hFFFF_FFFF : 32'h0);
          check("ld_wr_next_en", acc_wne, fe.wr ? 32'h7FFF_FFFF : 32'h0);
          void'(ld_q.pop_front());
        end
      end else begin
        check("ld_idle_outputs", 32'({wr_en, wr_next_en, data_rd, data_rd_next, ld_done}),
              32'd0);
      end

      st_hit = (st_q.size() > 0) && (st_q[0].done == cyc);
      check("st_done", 32'(st_done), 32'(st_hit));
      if (st_hit) begin
        cur_st = st_q[0].word;
        void'(st_q.pop_front());
      end
      check("st_data", st_data, cur_st);

      // A reset cycle abandons everything not already completing this cycle.
      if (!rstn) begin
        while (ld_q.size() > 0 && ld_q[$].done > cyc) void'(ld_q.pop_back());
        while (st_q.size() > 0 && st_q[$].done > cyc) void'(st_q.pop_back());
        cur_st    = '0;
        after_rst = 1'b1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $fatal(1);
  end

  initial begin
    int unsigned acc0;
    int          n;
    errors = 0; checks = 0; cyc = 0; ld_free = 0; st_free = 0; ld_acc_cnt = 0;
    cur_st = '0; after_rst = 1'b0;
    acc_d = '0; acc_dn = '0; acc_we = '0; acc_wne = '0;
    for (int i = 0; i < 256; i++) rs2_words[i] = $urandom;
    counter = 5'd0;
    data_rs2 = 1'b0;

    // Reset with requests held high.
    rstn = 1'b0; ld_valid = 1'b1; st_req = 1'b1;
    ld_data = 32'h1234_5678; ld_size = 2'd2; ld_unsigned = 1'b0; ld_rd = 4'd3;
    for (int i = 0; i < 6; i++) tick();
    rstn = 1'b1; ld_valid = 1'b0; st_req = 1'b0;
    tick();

    // Word load accepted at counter 31.
    wait_cnt(31);
    issue_load(32'hDEAD_BEEF, 2'd2, 1'b0, 4'd5);
    drain_ld();

    // Extensions, accepted at counter 10.
    wait_cnt(10);
    issue_load(32'h0000_0080, 2'd0, 1'b0, 4'd1);
    drain_ld();
    wait_cnt(10);
    issue_load(32'h0000_0080, 2'd0, 1'b1, 4'd2);
    drain_ld();
    wait_cnt(10);
    issue_load(32'h1234_8001, 2'd1, 1'b0, 4'd3);
    drain_ld();

    // x0 destination, then a back-to-back load held valid.
    wait_cnt(31);
    ld_valid = 1'b1; ld_data = $urandom; ld_size = 2'd2; ld_unsigned = 1'b0; ld_rd = 4'd0;
    tick();
    ld_rd = 4'd7; ld_data = $urandom;
    acc0 = ld_acc_cnt;
    n = 0;
    while (ld_acc_cnt == acc0 && n < 64) begin
      tick();
      n++;
    end
    ld_valid = 1'b0;
    drain_ld();

    // Store of 0xCAFEF00D requested at counter 3, plus an ignored request while busy.
    wait_cnt(3);
    rs2_words[8'(cyc / 32 + 1)] = 32'hCAFE_F00D;
    st_req = 1'b1;
    tick();
    st_req = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    st_req = 1'b1;
    tick();
    st_req = 1'b0;
    drain_st();

    // Reset in the middle of a load stream.
    wait_cnt(31);
    issue_load(32'hA5A5_0F0F, 2'd2, 1'b0, 4'd9);
    wait_cnt(12);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) tick();

    // Reset during concurrent load and store.
    wait_cnt(20);
    ld_valid = 1'b1; ld_data = $urandom; ld_size = 2'd2; ld_rd = 4'd4; st_req = 1'b1;
    tick();
    ld_valid = 1'b0; st_req = 1'b0;
    wait_cnt(31);
    tick();
    wait_cnt(12);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) tick();

    // Concurrent load and store running to completion.
    wait_cnt(5);
    ld_valid = 1'b1; ld_data = $urandom; ld_size = 2'd1; ld_unsigned = 1'b0; ld_rd = 4'd11;
    st_req = 1'b1;
    tick();
    ld_valid = 1'b0; st_req = 1'b0;
    drain_ld();
    drain_st();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      ld_valid    = ($urandom_range(0, 7) == 0);
      ld_data     = $urandom;
      ld_size     = 2'($urandom_range(0, 3));
      ld_unsigned = 1'($urandom_range(0, 1));
      ld_rd       = 4'($urandom_range(0, 15));
      st_req      = ($urandom_range(0, 9) == 0);
      rstn        = !($urandom_range(0, 299) == 0);
      tick();
    end

    rstn = 1'b1; ld_valid = 1'b0; st_req = 1'b0;
    for (int i = 0; i < 80; i++) tick();
    @(negedge clk);
    #1;
    check("ld_queue_drained", 32'(ld_q.size()), 32'd0);
    check("st_queue_drained", 32'(st_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nanov_reg_serdes.md
Name: nanov_reg_serdes

Overview:
- Parallel-to-bit-serial bridge between the nanoV memory interface and the 1-bit serial register file.
- Load path: accepts a 32-bit load word, then size/sign-extends it. It drives the result onto the register file write stream (data_rd, data_rd_next, wr_en, wr_next_en, rd), aligned to the core bit counter.
- Store path: collects the serial rs2 read stream into a parallel 32-bit store word.
- Sits between the core sequencer/memory controller and the register file.

Parameters:
- REG_ADDR_BITS, 4, width of the register address (RV32E).
- NUM_REGS, 16, registers implemented. Destinations of 0 or >= NUM_REGS are non-writable.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- counter  in  5  core bit counter; increments every clk and wraps 31->0
- ld_valid  in  1  load word available
- ld_ready  out  1  load path idle, can accept
- ld_data  in  32  raw load word, byte 0 in [7:0]
- ld_size  in  2  0=byte, 1=half, 2=word; 3 is treated as word
- ld_unsigned  in  1  1=zero-extend, 0=sign-extend
- ld_rd  in  REG_ADDR_BITS  destination register
- rd  out  REG_ADDR_BITS  latched destination for the register file
- wr_en  out  1  write data_rd into bit [counter] of rd
- wr_next_en  out  1  write data_rd_next into bit [counter+1] of rd
- data_rd  out  1  result bit [counter]
- data_rd_next  out  1  result bit [counter+1]
- ld_done  out  1  one-cycle pulse: last bit being written
- st_req  in  1  request capture of the rs2 stream
- st_busy  out  1  capture pending or in progress
- data_rs2  in  1  serial rs2 bit for the current counter
- st_data  out  32  captured store word
- st_done  out  1  one-cycle pulse: st_data updated

Behaviour:

Reset:
- Load FSM = IDLE; store FSM = S_IDLE.
- ld_ready=1; all other outputs 0, including rd and st_data.
- Reset mid-operation abandons the transfer: no further wr_en, no done pulse.

Load FSM states: IDLE, ARM, SHIFT.
- IDLE:
  - ld_ready=1.
  - On ld_valid, latch ld_rd into rd and latch the extended word into a 32-bit shift register W.
  - Next state is SHIFT if counter==31 at accept, else ARM.
- Extension rules:
  - byte: W = {24{ld_unsigned?0:ld_data[7]}}, ld_data[7:0].
  - half: W = {16{ld_unsigned?0:ld_data[15]}}, ld_data[15:0].
  - word: W = ld_data.
- ARM:
  - ld_ready=0; outputs idle.
  - Go to SHIFT on the cycle where counter==31.
- SHIFT (exactly 32 cycles, counter 0..31):
  - data_rd = W[counter]; data_rd_next = W[counter+1] for counter<=30, and 0 at counter 31.
  - wr_en=1 for all 32 cycles; wr_next_en=1 for counter 0..30 and 0 at 31.
  - Both enables are forced 0 when rd==0 or rd>=NUM_REGS. Timing is unchanged in that case and ld_done still pulses.
  - ld_done=1 at counter==31. Next state is IDLE, so ld_ready=1 the following cycle.
- Latency: first written bit appears 1 cycle after accept at best (accept at counter 31) and 32 cycles at worst. Completion is always 32 cycles after SHIFT entry.
- Outside SHIFT: wr_en, wr_next_en, data_rd and data_rd_next are 0.
- Implementation may index W directly by counter or shift W; the bit alignment above is mandatory.

Store FSM states: S_IDLE, S_WAIT, S_CAP.
- S_IDLE:
  - st_req moves to S_CAP if counter==31, else to S_WAIT.
  - st_busy=1 from the following cycle until st_done.
- S_WAIT: go to S_CAP when counter==31.
- S_CAP (counter 0..31): capture data_rs2 into an internal buffer bit [counter].
- After the counter==31 capture:
  - Next cycle: st_data <= buffer, st_done=1 for one cycle, st_busy=0, state S_IDLE.
  - st_data holds its value until the next completed capture.
- st_req while st_busy is ignored.
- A new st_req in the st_done cycle is accepted.

Concurrency:
- Load and store paths are fully independent and may overlap.
- A store capturing rs2==rd while a load writes rd is the sequencer's responsibility.

Test Plan:
- Reset with ld_valid=1, st_req=1 held. Required: ld_ready=1, all other outputs 0, st_data=0, no wr_en during reset.
- Word load: ld_data=0xDEADBEEF, ld_rd=5, accepted at counter==31. Required: next 32 cycles have wr_en=1, data_rd bit c = bit c of 0xDEADBEEF, data_rd_next = bit c+1 with wr_next_en=0 at c=31, rd=5, and a single ld_done pulse at counter 31.
- Extension, each accepted at counter==10 (one ARM stretch of 21 cycles before SHIFT):
  - ld_data=0x00000080, byte, signed -> serial 0xFFFFFF80.
  - Same with unsigned -> 0x00000080.
  - ld_data=0x12348001, half, signed -> 0xFFFF8001.
- Destination x0 and back-to-back: ld_rd=0 -> wr_en and wr_next_en stay 0 for all 32 cycles while ld_done still pulses. Then ld_valid is held high with ld_rd=7: the second load is accepted the cycle after ld_done at counter 0 (31-cycle ARM), and its write stream starts at the next counter 0, 32 cycles after accept.
- Store: st_req at counter 3, data_rs2 driving 0xCAFEF00D serially. Required: st_busy=1 until done; capture on counter 0..31; st_data=0xCAFEF00D; st_done pulses once the cycle after counter 31. A second st_req during busy is ignored.
- Reset mid-operation: assert rstn=0 at SHIFT counter 12. Required: wr_en=0 next cycle, no ld_done, FSM in IDLE, ld_ready=1 after release. Repeat with a concurrent load and store to check the two paths do not interfere.
